// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I OP/OP-IMM issue path to the external ALU.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {KIND_NORMAL, KIND_SLT, KIND_SLTU, KIND_ILLEGAL} kind_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;
  typedef enum logic [1:0] {OPB_RS2, OPB_IMM, OPB_SHAMT} opb_sel_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / result-out handshake bundle for alu_issue_ctrl.
interface alu_issue_ctrl_if import alu_pkg::*; ();

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_instr;
  logic [XLEN-1:0]    in_rs1_data;
  logic [XLEN-1:0]    in_rs2_data;
  logic               res_valid;
  logic               res_ready;
  logic [RADDR_W-1:0] res_rd;
  logic [XLEN-1:0]    res_data;
  logic               res_illegal;

  modport master (
    output in_valid, in_instr, in_rs1_data, in_rs2_data, res_ready,
    input  in_ready, res_valid, res_rd, res_data, res_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1_data, in_rs2_data, res_ready,
    output in_ready, res_valid, res_rd, res_data, res_illegal
  );

endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational decode of OP/OP-IMM fields into ALU opcode, operand-B source and result kind.
module alu_issue_ctrl_decode import alu_pkg::*; (
  input  logic [6:0] i_opc,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output alu_op_e    o_alu_op,
  output opb_sel_e   o_opb_sel,
  output kind_e      o_kind
);

  logic w_is_op, w_is_imm, w_f7_zero, w_f7_alt, w_legal;
  kind_e w_kind;

  assign w_is_op   = (i_opc == OPC_OP);
  assign w_is_imm  = (i_opc == OPC_OP_IMM);
  assign w_f7_zero = (i_funct7 == 7'b0000000);
  assign w_f7_alt  = (i_funct7 == 7'b0100000);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_opb_sel = w_is_imm ? OPB_IMM : OPB_RS2;
    w_kind    = KIND_NORMAL;
    w_legal   = 1'b0;
    unique case (i_funct3)
      3'b000: begin
        o_alu_op = (w_is_op && w_f7_alt) ? ALU_SUB : ALU_ADD;
        w_legal  = w_is_imm || w_f7_zero || w_f7_alt;
      end
      3'b001: begin
        o_alu_op = ALU_SLL;
        if (w_is_imm) o_opb_sel = OPB_SHAMT;
        w_legal  = w_f7_zero;
      end
      3'b010: begin
        o_alu_op = ALU_SUB;
        w_kind   = KIND_SLT;
        w_legal  = w_is_imm || w_f7_zero;
      end
      3'b011: begin
        o_alu_op = ALU_SUB;
        w_kind   = KIND_SLTU;
        w_legal  = w_is_imm || w_f7_zero;
      end
      3'b100: begin o_alu_op = ALU_XOR; w_legal = w_is_imm || w_f7_zero; end
      3'b101: begin
        o_alu_op = w_f7_alt ? ALU_SRA : ALU_SRL;
        if (w_is_imm) o_opb_sel = OPB_SHAMT;
        w_legal  = w_f7_zero || w_f7_alt;
      end
      3'b110: begin o_alu_op = ALU_OR;  w_legal = w_is_imm || w_f7_zero; end
      default: begin o_alu_op = ALU_AND; w_legal = w_is_imm || w_f7_zero; end
    endcase
  end

  assign o_kind = ((w_is_op || w_is_imm) && w_legal) ? w_kind : KIND_ILLEGAL;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one OP/OP-IMM instruction at a time to an external combinational ALU and returns rd/result.
module alu_issue_ctrl import alu_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  alu_issue_ctrl_if.slave     bus,
  output logic [2:0]          alu_opcode,
  output logic [XLEN-1:0]     alu_op_0,
  output logic [XLEN-1:0]     alu_op_1,
  input  logic [XLEN-1:0]     alu_out,
  input  logic                alu_negative
);

  state_e             r_state;
  kind_e              r_kind;
  logic [RADDR_W-1:0] r_rd;

  alu_op_e          w_dec_op;
  opb_sel_e         w_dec_opb;
  kind_e            w_dec_kind;
  logic [XLEN-1:0]  w_op_1;
  logic             w_lt;
  logic             w_unused;

  assign w_unused = ^bus.in_instr[19:15];

  alu_issue_ctrl_decode u_decode (
    .i_opc     (bus.in_instr[6:0]),
    .i_funct3  (bus.in_instr[14:12]),
    .i_funct7  (bus.in_instr[31:25]),
    .o_alu_op  (w_dec_op),
    .o_opb_sel (w_dec_opb),
    .o_kind    (w_dec_kind)
  );

  always_comb begin
    unique case (w_dec_opb)
      OPB_IMM:   w_op_1 = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      OPB_SHAMT: w_op_1 = {27'b0, bus.in_instr[24:20]};
      default:   w_op_1 = bus.in_rs2_data;
    endcase
  end

  // Mixed signs decide the compare directly, so SUB overflow never matters.
  assign w_lt = (alu_op_0[XLEN-1] != alu_op_1[XLEN-1])
              ? ((r_kind == KIND_SLT) ? alu_op_0[XLEN-1] : alu_op_1[XLEN-1])
              : alu_negative;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_kind          <= KIND_NORMAL;
      r_rd            <= '0;
      bus.in_ready    <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.res_rd      <= '0;
      bus.res_data    <= '0;
      bus.res_illegal <= 1'b0;
      alu_opcode      <= ALU_ADD;
      alu_op_0        <= '0;
      alu_op_1        <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (bus.in_valid) begin
          bus.in_ready <= 1'b0;
          r_rd         <= bus.in_instr[11:7];
          r_kind       <= w_dec_kind;
          if (w_dec_kind != KIND_ILLEGAL) begin
            alu_opcode <= w_dec_op;
            alu_op_0   <= bus.in_rs1_data;
            alu_op_1   <= w_op_1;
          end
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          bus.res_valid   <= 1'b1;
          bus.res_rd      <= r_rd;
          bus.res_illegal <= (r_kind == KIND_ILLEGAL);
          unique case (r_kind)
            KIND_ILLEGAL:        bus.res_data <= '0;
            KIND_SLT, KIND_SLTU: bus.res_data <= {{(XLEN-1){1'b0}}, w_lt};
            default:             bus.res_data <= alu_out;
          endcase
          r_state <= ST_RESP;
        end
        ST_RESP: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: begin
          bus.res_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_op_0, alu_op_1, alu_out;
  logic        alu_negative;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .alu_opcode   (alu_opcode),
    .alu_op_0     (alu_op_0),
    .alu_op_1     (alu_op_1),
    .alu_out      (alu_out),
    .alu_negative (alu_negative)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    case (alu_opcode)
      3'b000:  alu_out = alu_op_0 + alu_op_1;
      3'b001:  alu_out = alu_op_0 - alu_op_1;
      3'b010:  alu_out = alu_op_0 & alu_op_1;
      3'b011:  alu_out = alu_op_0 | alu_op_1;
      3'b100:  alu_out = alu_op_0 ^ alu_op_1;
      3'b101:  alu_out = alu_op_0 << alu_op_1[4:0];
      3'b110:  alu_out = alu_op_0 >> alu_op_1[4:0];
      default: alu_out = $unsigned($signed(alu_op_0) >>> alu_op_1[4:0]);
    endcase
    alu_negative = alu_out[31];
  end

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  // Presents a beat, waits (bounded) for in_ready, and returns #1 after the accepting edge.
  task automatic do_issue(input logic [31:0] instr, rs1, rs2, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_rs1_data = rs1; bus.in_rs2_data = rs2;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL issue_accept: in_ready never rose (instr=%h)", instr); end
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!bus.res_valid && n < 10) begin @(posedge clk); #1; n++; end
  endtask

  // One full transaction with res_ready high: checks ALU drive, latency and result beat.
  task automatic run_op(input string name, input logic [31:0] instr, rs1, rs2,
                        input logic [2:0] e_opc, input logic [31:0] e_op1, e_data, input logic e_ill);
    bit ok; int n;
    do_issue(instr, rs1, rs2, ok);
    checks++;
    if (!e_ill && {alu_opcode, alu_op_0, alu_op_1} !== {e_opc, rs1, e_op1}) begin
      errors++;
      $display("FAIL %s_alu_drive: got opc=%b op0=%h op1=%h want opc=%b op0=%h op1=%h",
               name, alu_opcode, alu_op_0, alu_op_1, e_opc, rs1, e_op1);
    end
    wait_result(n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL %s_latency: got %0d edges want 1", name, n); end
    checks++;
    if ({bus.res_valid, bus.res_rd, bus.res_data, bus.res_illegal} !== {1'b1, instr[11:7], e_data, e_ill}) begin
      errors++;
      $display("FAIL %s_result: got v=%b rd=%0d data=%h ill=%b want v=1 rd=%0d data=%h ill=%b",
               name, bus.res_valid, bus.res_rd, bus.res_data, bus.res_illegal, instr[11:7], e_data, e_ill);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    bus.in_instr = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready, bus.res_valid, bus.res_rd, bus.res_data, bus.res_illegal} !== {1'b1, 1'b0, 5'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_res: got rdy=%b v=%b rd=%0d data=%h ill=%b", bus.in_ready, bus.res_valid,
               bus.res_rd, bus.res_data, bus.res_illegal);
    end
    checks++;
    if ({alu_opcode, alu_op_0, alu_op_1} !== 67'd0) begin
      errors++;
      $display("FAIL reset_alu: got opc=%b op0=%h op1=%h want zeros", alu_opcode, alu_op_0, alu_op_1);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add_sub_shift();
    run_op("add",  r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, OPC_OP), 32'd5, 32'd7, 3'b000, 32'd7, 32'd12, 1'b0);
    checks++;
    if ({bus.in_ready, bus.res_valid} !== 2'b10) begin
      errors++; $display("FAIL add_release: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.res_valid);
    end
    run_op("sub",  r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4, OPC_OP), 32'd3, 32'd5, 3'b001, 32'd5, 32'hFFFF_FFFE, 1'b0);
    run_op("srai", i_type({7'b0100000, 5'd4}, 5'd1, 3'b101, 5'd5, OPC_OP_IMM), 32'h8000_0000, 32'h1234_5678,
           3'b111, 32'd4, 32'hF800_0000, 1'b0);
    run_op("addi", i_type(12'hFFF, 5'd1, 3'b000, 5'd6, OPC_OP_IMM), 32'd10, 32'h0, 3'b000, 32'hFFFF_FFFF, 32'd9, 1'b0);
    run_op("sll",  r_type(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd7, OPC_OP), 32'h0000_0003, 32'h0000_0024,
           3'b101, 32'h0000_0024, 32'h0000_0030, 1'b0);
    run_op("and",  r_type(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd8, OPC_OP), 32'hFF00_FF00, 32'h0FF0_0FF0,
           3'b010, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0);
  endtask

  task automatic test_slt();
    run_op("slt",  r_type(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd10, OPC_OP), 32'h7FFF_FFFF, 32'h8000_0000,
           3'b001, 32'h8000_0000, 32'd0, 1'b0);
    run_op("sltu", r_type(7'b0000000, 5'd2, 5'd1, 3'b011, 5'd11, OPC_OP), 32'h7FFF_FFFF, 32'h8000_0000,
           3'b001, 32'h8000_0000, 32'd1, 1'b0);
    run_op("slt_same_sign", r_type(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd13, OPC_OP), 32'd4, 32'd9,
           3'b001, 32'd9, 32'd1, 1'b0);
    run_op("slti", i_type(12'h000, 5'd1, 3'b010, 5'd12, OPC_OP_IMM), 32'hFFFF_FFFF, 32'h5555_5555,
           3'b001, 32'd0, 32'd1, 1'b0);
  endtask

  task automatic test_illegal();
    // Prior instruction was SLTI rs1=-1 imm=0, so the ALU must still show SUB / FFFFFFFF / 0.
    run_op("mul", r_type(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd14, OPC_OP), 32'd6, 32'd7, 3'b000, 32'd0, 32'd0, 1'b1);
    checks++;
    if ({alu_opcode, alu_op_0, alu_op_1} !== {3'b001, 32'hFFFF_FFFF, 32'd0}) begin
      errors++;
      $display("FAIL mul_alu_hold: got opc=%b op0=%h op1=%h want 001/ffffffff/00000000", alu_opcode, alu_op_0, alu_op_1);
    end
    run_op("load_opc", i_type(12'h004, 5'd1, 3'b010, 5'd15, 7'b0000011), 32'd1, 32'd2, 3'b000, 32'd0, 32'd0, 1'b1);
    run_op("slli_bad", i_type({7'b0100000, 5'd3}, 5'd1, 3'b001, 5'd16, OPC_OP_IMM), 32'd1, 32'd2,
           3'b000, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_stall();
    bit ok; int n;
    bus.res_ready = 1'b0;
    do_issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd9, OPC_OP), 32'hF0F0_0000, 32'h0000_0F0F, ok);
    wait_result(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_instr = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OPC_OP);
      bus.in_rs1_data = 32'h1111_1111; bus.in_rs2_data = 32'h2222_2222;
      @(posedge clk); #1;
      checks++;
      if ({bus.res_valid, bus.in_ready, bus.res_rd, bus.res_data, alu_op_0} !==
          {1'b1, 1'b0, 5'd9, 32'hF0F0_0F0F, 32'hF0F0_0000}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b rdy=%b rd=%0d data=%h op0=%h want v=1 rdy=0 rd=9 data=f0f00f0f op0=f0f00000",
                 i, bus.res_valid, bus.in_ready, bus.res_rd, bus.res_data, alu_op_0);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.res_valid, bus.in_ready, alu_op_0} !== {1'b0, 1'b1, 32'hF0F0_0000}) begin
      errors++;
      $display("FAIL stall_release: got v=%b rdy=%b op0=%h want v=0 rdy=1 op0=f0f00000",
               bus.res_valid, bus.in_ready, alu_op_0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int t0, t1;
    do_issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd17, OPC_OP), 32'h0000_00FF, 32'h0000_0F0F, ok);
    t0 = cyc;
    do_issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd18, OPC_OP), 32'hFFFF_0000, 32'd8, ok);
    t1 = cyc;
    checks++;
    if (t1 - t0 != 3) begin errors++; $display("FAIL b2b_throughput: got %0d cycles want 3", t1 - t0); end
    @(posedge clk); #1;
    checks++;
    if ({bus.res_valid, bus.res_rd, bus.res_data} !== {1'b1, 5'd18, 32'h00FF_FF00}) begin
      errors++;
      $display("FAIL b2b_srl: got v=%b rd=%0d data=%h want v=1 rd=18 data=00ffff00", bus.res_valid, bus.res_rd, bus.res_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_exec();
    bit ok;
    do_issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd19, OPC_OP), 32'd40, 32'd2, ok);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.res_valid, bus.res_rd, bus.res_data, bus.res_illegal, alu_opcode, alu_op_0, alu_op_1} !==
        {1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 3'b000, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL rst_exec: got rdy=%b v=%b rd=%0d data=%h ill=%b opc=%b op0=%h op1=%h", bus.in_ready,
               bus.res_valid, bus.res_rd, bus.res_data, bus.res_illegal, alu_opcode, alu_op_0, alu_op_1);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.res_valid} !== 2'b10) begin
        errors++; $display("FAIL rst_exec_after[%0d]: got rdy=%b v=%b want rdy=1 v=0", i, bus.in_ready, bus.res_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub_shift();
    test_slt();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
